// File: rtl/rnn_fmt_pkg.sv
// Fixed-point widths and the sequencer state type shared by the MAC
// datapath and its controller.
package rnn_fmt_pkg;
  localparam int W_WEIGHT = 8;
  localparam int W_ACT    = 16;
  localparam int W_ACC    = 20;
  localparam int FRAC_ACT = 13;

  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_DRAIN, S_RESULT} mac_state_t;
endpackage

// File: rtl/adder_16_20_20.sv
// Adds a 1_2_13 term into a 1_6_13 accumulator, clamping to the
// accumulator range on overflow.
module adder_16_20_20 (
  input  logic [15:0] a,
  input  logic [19:0] b,
  output logic [19:0] s
);
  logic [20:0] sum;

  assign sum = {{5{a[15]}}, a} + {b[19], b};

  always_comb begin
    case (sum[20:19])
      2'b01:   s = 20'h7FFFF;
      2'b10:   s = 20'h80000;
      default: s = sum[19:0];
    endcase
  end
endmodule

// File: rtl/multiplier_8_16_16.sv
// Signed 1_2_5 x 1_2_13 multiply, truncated into a 1_2_13 result
// (no rounding, no saturation).
module multiplier_8_16_16 (
  input  logic [7:0]  a,
  input  logic [15:0] b,
  output logic [15:0] p
);
  logic [23:0] mul;
  logic        unused_mul_bits;

  assign mul = {{16{a[7]}}, a} * {{8{b[15]}}, b};
  assign p   = {mul[23], mul[19:18], mul[17:5]};
  assign unused_mul_bits = ^{mul[22:20], mul[4:0]};
endmodule

// File: rtl/rnn_mac_ctrl.sv
// Sequencer FSM: operand counting, input/output handshakes and the
// bias-load strobe for the accumulator.
module rnn_mac_ctrl
  import rnn_fmt_pkg::*;
#(
  parameter int MAX_LEN = 64,
  parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic             in_valid,
  input  logic             out_ready,
  output logic             in_ready,
  output logic             out_valid,
  output logic             accept,
  output logic             load_bias,
  output mac_state_t       state_o
);
  mac_state_t       state_q, state_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;

  // Valid/ready: a transfer happens on any rising edge where both are high;
  // ready depends only on state, never on valid.
  assign in_ready  = (state_q == S_ACCUM);
  assign out_valid = (state_q == S_RESULT);
  assign accept    = in_valid & in_ready;
  assign load_bias = (state_q == S_IDLE) & start;
  assign state_o   = state_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          cnt_d   = (len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : len;
          state_d = (len == '0) ? S_RESULT : S_ACCUM;
        end
      end
      S_ACCUM: begin
        if (in_valid) begin
          cnt_d = cnt_q - LEN_W'(1);
          if (cnt_q == LEN_W'(1)) state_d = S_DRAIN;
        end
      end
      S_DRAIN:  state_d = S_RESULT;
      S_RESULT: if (out_ready) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end
endmodule

// File: rtl/rnn_mac_sequencer.sv
// One-neuron pre-activation MAC: bias plus sum of W*X over a streamed
// operand sequence, multiply stage followed by a saturating accumulate.
module rnn_mac_sequencer
  import rnn_fmt_pkg::*;
#(
  parameter int MAX_LEN = 64,
  parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                START,
  input  logic [LEN_W-1:0]    LEN,
  input  logic [W_ACT-1:0]    BIAS,
  input  logic                IN_VALID,
  output logic                IN_READY,
  input  logic [W_WEIGHT-1:0] W,
  input  logic [W_ACT-1:0]    X,
  output logic                OUT_VALID,
  input  logic                OUT_READY,
  output logic [W_ACC-1:0]    OUT_DATA,
  output logic                BUSY
);
  mac_state_t       state;
  logic             accept;
  logic             load_bias;
  logic [W_ACT-1:0] mul_p;
  logic [W_ACC-1:0] add_s;

  logic [W_ACT-1:0] prod_q, prod_d;
  logic             p_valid_q, p_valid_d;
  logic [W_ACC-1:0] acc_q, acc_d;

  rnn_mac_ctrl #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W)) u_ctrl (
    .clk       (CLK),
    .rst       (RST),
    .start     (START),
    .len       (LEN),
    .in_valid  (IN_VALID),
    .out_ready (OUT_READY),
    .in_ready  (IN_READY),
    .out_valid (OUT_VALID),
    .accept    (accept),
    .load_bias (load_bias),
    .state_o   (state)
  );

  multiplier_8_16_16 u_mul (.a(W), .b(X), .p(mul_p));
  adder_16_20_20     u_add (.a(prod_q), .b(acc_q), .s(add_s));

  // The accumulate lags the multiply by one cycle; DRAIN exists to absorb it.
  always_comb begin
    prod_d    = accept ? mul_p : prod_q;
    p_valid_d = accept;
    acc_d     = acc_q;
    if (load_bias)      acc_d = {{(W_ACC - W_ACT){BIAS[W_ACT-1]}}, BIAS};
    else if (p_valid_q) acc_d = add_s;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      prod_q    <= '0;
      p_valid_q <= 1'b0;
      acc_q     <= '0;
    end else begin
      prod_q    <= prod_d;
      p_valid_q <= p_valid_d;
      acc_q     <= acc_d;
    end
  end

  assign OUT_DATA = acc_q;
  assign BUSY     = (state != S_IDLE);
endmodule

// File: tb/tb_rnn_mac_sequencer.sv
// Directed plus randomized bench for rnn_mac_sequencer against an
// arithmetic model of the fixed-point neuron sum.
module tb_rnn_mac_sequencer;
  localparam int MAX_LEN = 64;
  localparam int LEN_W   = $clog2(MAX_LEN + 1);

  logic             CLK = 1'b0;
  logic             RST;
  logic             START;
  logic [LEN_W-1:0] LEN;
  logic [15:0]      BIAS;
  logic             IN_VALID;
  logic             IN_READY;
  logic [7:0]       W;
  logic [15:0]      X;
  logic             OUT_VALID;
  logic             OUT_READY;
  logic [19:0]      OUT_DATA;
  logic             BUSY;

  int checks   = 0;
  int failures = 0;

  logic [7:0]  w_q[$];
  logic [15:0] x_q[$];
  int          gap_q[$];

  rnn_mac_sequencer #(.MAX_LEN(MAX_LEN)) dut (
    .CLK(CLK), .RST(RST), .START(START), .LEN(LEN), .BIAS(BIAS),
    .IN_VALID(IN_VALID), .IN_READY(IN_READY), .W(W), .X(X),
    .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .OUT_DATA(OUT_DATA),
    .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $display("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  // Product in units of 2^-13: the value of MUL>>5 with bits 22:20 of the
  // full product dropped and its sign kept.
  function automatic int model_prod(input logic [7:0] w, input logic [15:0] x);
    int m, f;
    m = int'($signed(w)) * int'($signed(x));
    f = (m >>> 5) & 32'h7FFF;
    return (m < 0) ? f - 32768 : f;
  endfunction

  function automatic logic [19:0] model_neuron(input int n, input logic [15:0] bias);
    int acc;
    acc = int'($signed(bias));
    for (int i = 0; i < n; i++) begin
      acc = acc + model_prod(w_q[i], x_q[i]);
      if (acc > 524287)  acc = 524287;
      if (acc < -524288) acc = -524288;
    end
    return acc[19:0];
  endfunction

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  // hold < 0: OUT_READY high from the start; otherwise OUT_READY low for
  // hold cycles of RESULT.
  task automatic run_neuron(input string tag, input int len, input logic [15:0] bias,
                            input int hold, input bit poke_start, output logic [19:0] res);
    int          eff;
    logic [19:0] exp;
    eff = (len > MAX_LEN) ? MAX_LEN : len;
    exp = model_neuron(eff, bias);
    START = 1'b1; LEN = LEN_W'(len); BIAS = bias;
    OUT_READY = (hold < 0);
    tick();
    START = 1'b0;
    chk({tag, " busy"}, 32'(BUSY), 32'd1);
    for (int i = 0; i < eff; i++) begin
      for (int g = 0; g < gap_q[i]; g++) begin
        IN_VALID = 1'b0;
        START = 1'($urandom_range(0, 1));
        chk({tag, " gap_ready"}, 32'(IN_READY), 32'd1);
        tick();
      end
      START = 1'b0;
      IN_VALID = 1'b1; W = w_q[i]; X = x_q[i];
      chk({tag, " in_ready"}, 32'(IN_READY), 32'd1);
      tick();
    end
    IN_VALID = (len > MAX_LEN);
    W = 8'($urandom); X = 16'($urandom);
    if (eff > 0) begin
      chk({tag, " drain_ready"}, 32'(IN_READY), 32'd0);
      chk({tag, " drain_valid"}, 32'(OUT_VALID), 32'd0);
      tick();
    end
    chk({tag, " out_valid"}, 32'(OUT_VALID), 32'd1);
    chk({tag, " out_data"}, 32'(OUT_DATA), 32'(exp));
    res = OUT_DATA;
    for (int h = 0; h < hold; h++) begin
      IN_VALID = 1'b1;
      if (poke_start) begin START = 1'b1; LEN = LEN_W'(5); end
      tick();
      chk({tag, " hold_valid"}, 32'(OUT_VALID), 32'd1);
      chk({tag, " hold_data"}, 32'(OUT_DATA), 32'(exp));
      chk({tag, " hold_ready"}, 32'(IN_READY), 32'd0);
    end
    START = 1'b0; IN_VALID = 1'b0; OUT_READY = 1'b1;
    tick();
    chk({tag, " valid_fall"}, 32'(OUT_VALID), 32'd0);
    chk({tag, " idle"}, 32'(BUSY), 32'd0);
    OUT_READY = 1'b0;
  endtask

  task automatic load_fixed(input int n, input logic [7:0] w, input logic [15:0] x);
    w_q.delete(); x_q.delete(); gap_q.delete();
    for (int i = 0; i < n; i++) begin
      w_q.push_back(w); x_q.push_back(x); gap_q.push_back(0);
    end
  endtask

  task automatic load_random(input int n);
    w_q.delete(); x_q.delete(); gap_q.delete();
    for (int i = 0; i < n; i++) begin
      w_q.push_back(8'($urandom));
      x_q.push_back(16'($urandom));
      gap_q.push_back($urandom_range(0, 2));
    end
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, " in_ready"}, 32'(IN_READY), 32'd0);
    chk({tag, " out_valid"}, 32'(OUT_VALID), 32'd0);
    chk({tag, " out_data"}, 32'(OUT_DATA), 32'd0);
    chk({tag, " busy"}, 32'(BUSY), 32'd0);
  endtask

  initial begin
    logic [19:0] res;
    int          len;

    RST = 1'b1; START = 1'b0; LEN = '0; BIAS = '0; IN_VALID = 1'b0;
    W = '0; X = '0; OUT_READY = 1'b0;
    repeat (3) tick();
    chk_zero_outputs("reset");
    RST = 1'b0;
    tick();

    load_fixed(1, 8'h20, 16'h2000);
    run_neuron("one", 1, 16'h0000, 0, 1'b0, res);
    chk("one value", 32'(res), 32'h02000);

    load_fixed(4, 8'h20, 16'h2000);
    gap_q[1] = 1; gap_q[2] = 3;
    run_neuron("gaps", 4, 16'h1000, 1, 1'b0, res);
    chk("gaps value", 32'(res), 32'h09000);

    load_fixed(32, 8'h40, 16'h3000);
    run_neuron("sat_pos", 32, 16'h0000, -1, 1'b0, res);
    chk("sat_pos value", 32'(res), 32'h7FFFF);

    load_fixed(32, 8'hC0, 16'h3000);
    run_neuron("sat_neg", 32, 16'h0000, 0, 1'b0, res);
    chk("sat_neg value", 32'(res), 32'h80000);

    load_fixed(0, 8'h00, 16'h0000);
    run_neuron("len0", 0, 16'hE000, 5, 1'b1, res);
    chk("len0 value", 32'(res), 32'hFE000);

    // Abort a run part way through with an asynchronous reset.
    load_fixed(8, 8'h40, 16'h3000);
    START = 1'b1; LEN = LEN_W'(8); BIAS = 16'h1234;
    tick();
    START = 1'b0;
    for (int i = 0; i < 3; i++) begin
      IN_VALID = 1'b1; W = w_q[i]; X = x_q[i];
      tick();
    end
    RST = 1'b1;
    #1;
    chk_zero_outputs("abort");
    tick();
    RST = 1'b0; IN_VALID = 1'b0;
    tick();
    load_fixed(1, 8'h20, 16'h2000);
    run_neuron("after_abort", 1, 16'h0000, 0, 1'b0, res);
    chk("after_abort value", 32'(res), 32'h02000);

    load_random(MAX_LEN);
    run_neuron("clamp", 70, 16'($urandom), 0, 1'b0, res);

    for (int t = 0; t < 6; t++) begin
      len = $urandom_range(1, 12);
      load_random(len);
      run_neuron("rand", len, 16'($urandom), $urandom_range(0, 4) - 1, 1'b0, res);
    end

    load_fixed(40, 8'h7F, 16'h7FFF);
    for (int i = 20; i < 40; i++) begin w_q[i] = 8'h80; x_q[i] = 16'h7FFF; end
    run_neuron("sat_recover", 40, 16'h8000, 0, 1'b0, res);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
